// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI driver between NUM_REQ requesters.
// Checks each request's length, runs the driver start/ready handshake and returns the masked rx word.
module spi_txn_arbiter #(
    parameter int  NUM_REQ      = 4,
    parameter int  SPI_MAXLEN   = 16,
    parameter int  BUSY_TIMEOUT = 15,
    localparam int LW           = $clog2(SPI_MAXLEN) + 1,
    localparam int IW           = $clog2(NUM_REQ)
) (
    input  logic                          SCLK,
    input  logic                          sresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*LW-1:0]         req_n_clks,
    input  logic [NUM_REQ*SPI_MAXLEN-1:0] req_tx_data,
    output logic                          resp_valid,
    output logic [IW-1:0]                 resp_id,
    output logic                          resp_err,
    output logic [SPI_MAXLEN-1:0]         resp_data,
    output logic                          busy,
    output logic                          drv_start,
    input  logic                          drv_rdy,
    output logic [LW-1:0]                 drv_n_clks,
    output logic [SPI_MAXLEN-1:0]         drv_tx_data,
    input  logic [SPI_MAXLEN-1:0]         drv_rx_data
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t                state_q;
    logic [IW-1:0]         rr_ptr_q;
    logic [IW-1:0]         rr_ptr_d;
    logic [IW-1:0]         id_q;
    logic [LW-1:0]         n_clks_q;
    logic [SPI_MAXLEN-1:0] tx_data_q;
    logic [TW-1:0]         tmo_cnt_q;
    logic [IW-1:0]         resp_id_q;
    logic                  resp_err_q;
    logic [SPI_MAXLEN-1:0] resp_data_q;

    logic                  win_found;
    logic [IW-1:0]         win_id;
    logic [LW-1:0]         win_n_clks;
    logic [SPI_MAXLEN-1:0] win_tx_data;
    logic                  win_len_bad;
    logic [SPI_MAXLEN-1:0] rx_mask;

    // Requester index arithmetic modulo NUM_REQ; base + off never exceeds 2*NUM_REQ-1 here.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IW'(sum);
    endfunction

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
                win_found = 1'b1;
                win_id    = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && win_found) req_ready[win_id] = 1'b1;
    end

    assign win_n_clks  = req_n_clks[win_id*LW +: LW];
    assign win_tx_data = req_tx_data[win_id*SPI_MAXLEN +: SPI_MAXLEN];
    assign win_len_bad = (win_n_clks == '0) || (win_n_clks > LW'(SPI_MAXLEN));

    // A full-length transfer keeps every bit; shorter ones keep only the low n_clks bits.
    assign rx_mask = (n_clks_q >= LW'(SPI_MAXLEN)) ? '1
                   : ((SPI_MAXLEN'(1) << n_clks_q) - SPI_MAXLEN'(1));

    assign rr_ptr_d    = wrap_add(id_q, 1);

    assign busy        = (state_q != IDLE);
    assign drv_start   = (state_q == ISSUE);
    assign resp_valid  = (state_q == RESP);
    assign resp_id     = resp_id_q;
    assign resp_err    = resp_err_q;
    assign resp_data   = resp_data_q;
    assign drv_n_clks  = n_clks_q;
    assign drv_tx_data = tx_data_q;

    always_ff @(posedge SCLK or negedge sresetn) begin
        if (!sresetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            n_clks_q    <= '0;
            tx_data_q   <= '0;
            tmo_cnt_q   <= '0;
            resp_id_q   <= '0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        id_q <= win_id;
                        // Bad lengths are answered directly so the driver never sees them.
                        if (win_len_bad) begin
                            resp_id_q   <= win_id;
                            resp_err_q  <= 1'b1;
                            resp_data_q <= '0;
                            state_q     <= RESP;
                        end else begin
                            n_clks_q  <= win_n_clks;
                            tx_data_q <= win_tx_data;
                            state_q   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (drv_rdy) begin
                        tmo_cnt_q <= '0;
                        state_q   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!drv_rdy) begin
                        state_q <= WAIT_DONE;
                    end else if (tmo_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                        resp_id_q   <= id_q;
                        resp_err_q  <= 1'b1;
                        resp_data_q <= '0;
                        state_q     <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (drv_rdy) begin
                        resp_id_q   <= id_q;
                        resp_err_q  <= 1'b0;
                        resp_data_q <= drv_rx_data & rx_mask;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: directed and random transactions against a
// behavioural driver model and a round-robin reference model.
module tb_spi_txn_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int SPI_MAXLEN   = 16;
    localparam int BUSY_TIMEOUT = 15;
    localparam int LW           = $clog2(SPI_MAXLEN) + 1;
    localparam int IW           = $clog2(NUM_REQ);

    logic                          SCLK        = 1'b0;
    logic                          sresetn     = 1'b1;
    logic [NUM_REQ-1:0]            req_valid   = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*LW-1:0]         req_n_clks  = '0;
    logic [NUM_REQ*SPI_MAXLEN-1:0] req_tx_data = '0;
    logic                          resp_valid;
    logic [IW-1:0]                 resp_id;
    logic                          resp_err;
    logic [SPI_MAXLEN-1:0]         resp_data;
    logic                          busy;
    logic                          drv_start;
    logic                          drv_rdy;
    logic [LW-1:0]                 drv_n_clks;
    logic [SPI_MAXLEN-1:0]         drv_tx_data;
    logic [SPI_MAXLEN-1:0]         drv_rx_data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic                  rdyModel;
    logic                  drvActive;
    int                    drvCnt;
    logic [SPI_MAXLEN-1:0] rxOut;
    int                    startEdges    = 0;
    int                    lastStartEdge = -1;
    int                    handshakeEdge = -1;
    int                    riseEdge      = -1;
    logic [LW-1:0]         hsN;
    logic [SPI_MAXLEN-1:0] hsTx;

    logic                  drvForceLow = 1'b0;
    logic                  drvStuck    = 1'b0;
    logic                  drvRxMode   = 1'b0;
    int                    drvLat      = 2;
    logic [SPI_MAXLEN-1:0] drvRxConst  = '0;

    int                    rrPtr = 0;
    int                    nArr[NUM_REQ];
    logic [SPI_MAXLEN-1:0] txArr[NUM_REQ];

    spi_txn_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .SPI_MAXLEN  (SPI_MAXLEN),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .SCLK       (SCLK),
        .sresetn    (sresetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_n_clks (req_n_clks),
        .req_tx_data(req_tx_data),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .resp_data  (resp_data),
        .busy       (busy),
        .drv_start  (drv_start),
        .drv_rdy    (drv_rdy),
        .drv_n_clks (drv_n_clks),
        .drv_tx_data(drv_tx_data),
        .drv_rx_data(drv_rx_data)
    );

    always #5 SCLK = ~SCLK;

    always @(posedge SCLK) cyc <= cyc + 1;

    assign drv_rdy     = rdyModel & ~drvForceLow;
    assign drv_rx_data = rxOut;

    // SPI driver model: takes a start while ready, stays busy drvLat cycles, then returns rx.
    always @(posedge SCLK or negedge sresetn) begin
        if (!sresetn) begin
            rdyModel  <= 1'b1;
            drvActive <= 1'b0;
            drvCnt    <= 0;
            rxOut     <= '0;
        end else begin
            if (drv_start === 1'b1) begin
                startEdges    <= startEdges + 1;
                lastStartEdge <= cyc + 1;
            end
            if (drv_start === 1'b1 && drv_rdy === 1'b1) begin
                handshakeEdge <= cyc + 1;
                hsN           <= drv_n_clks;
                hsTx          <= drv_tx_data;
            end
            if (!drvActive) begin
                if (drv_start === 1'b1 && drv_rdy === 1'b1 && !drvStuck) begin
                    drvActive <= 1'b1;
                    drvCnt    <= drvLat;
                    rdyModel  <= 1'b0;
                end
            end else if (drvCnt == 0) begin
                rdyModel  <= 1'b1;
                drvActive <= 1'b0;
                rxOut     <= drvRxMode ? drvRxConst : drv_tx_data;
                riseEdge  <= cyc + 1;
            end else begin
                drvCnt <= drvCnt - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge SCLK) begin
        if (sresetn === 1'b1) checkOutput("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    end

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    function automatic int refWinner(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [SPI_MAXLEN-1:0] refMask(input int n);
        return SPI_MAXLEN'((64'd1 << n) - 64'd1);
    endfunction

    task automatic applyStimulus(input logic [NUM_REQ-1:0] vmask);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_n_clks[i*LW +: LW]                 = LW'(nArr[i]);
            req_tx_data[i*SPI_MAXLEN +: SPI_MAXLEN] = txArr[i];
        end
        req_valid = vmask;
    endtask

    // One full transaction from IDLE: grant, driver sequencing, response, return to IDLE.
    task automatic doTxn(input logic [NUM_REQ-1:0] vmask, input int holdOff, input logic stuck,
                         input logic ghost);
        int                    win, n, acc, cycles, base, g, nxt;
        logic                  lenBad, expErr;
        logic [SPI_MAXLEN-1:0] rx, expData;
        logic [NUM_REQ-1:0]    left;
        win     = refWinner(vmask, rrPtr);
        n       = nArr[win];
        lenBad  = (n == 0) || (n > SPI_MAXLEN);
        expErr  = lenBad || stuck;
        rx      = drvRxMode ? drvRxConst : txArr[win];
        expData = expErr ? '0 : (rx & refMask(n));
        drvStuck    = stuck;
        drvForceLow = (holdOff > 0);
        applyStimulus(vmask);
        #1;
        checkOutput("grant", 32'(req_ready), 32'(1 << win));
        checkOutput("busy_idle", 32'(busy), 32'd0);
        base = startEdges;
        tick();
        acc  = cyc;
        left = vmask & ~(NUM_REQ'(1) << win);
        req_valid = left;
        req_n_clks[win*LW +: LW]                 = LW'($urandom);
        req_tx_data[win*SPI_MAXLEN +: SPI_MAXLEN] = SPI_MAXLEN'($urandom);
        checkOutput("ready_busy", 32'(req_ready), 32'd0);
        g      = (win + 2) % NUM_REQ;
        cycles = 0;
        while (resp_valid !== 1'b1 && cycles < 300) begin
            if (cycles >= holdOff) drvForceLow = 1'b0;
            if (ghost && cycles == 1) req_valid[g] = 1'b1;
            tick();
            cycles++;
        end
        drvForceLow = 1'b0;
        checkOutput("resp_seen", 32'(resp_valid), 32'd1);
        checkOutput("resp_id", 32'(resp_id), 32'(win));
        checkOutput("resp_err", 32'(resp_err), 32'(expErr));
        checkOutput("resp_data", 32'(resp_data), 32'(expData));
        if (lenBad) begin
            checkOutput("reject_latency", 32'(cyc - acc), 32'd0);
            checkOutput("reject_no_start", 32'(startEdges - base), 32'd0);
        end else begin
            checkOutput("start_cycles", 32'(startEdges - base), 32'(holdOff + 1));
            checkOutput("start_last", 32'(lastStartEdge), 32'(acc + holdOff + 1));
            checkOutput("drv_n_clks", 32'(hsN), 32'(n));
            checkOutput("drv_tx_data", 32'(hsTx), 32'(txArr[win]));
            if (stuck) checkOutput("timeout_latency", 32'(cyc - handshakeEdge), 32'(BUSY_TIMEOUT));
            else       checkOutput("done_latency", 32'(cyc - riseEdge), 32'd1);
        end
        if (ghost) req_valid[g] = 1'b0;
        rrPtr = (win + 1) % NUM_REQ;
        tick();
        checkOutput("resp_pulse", 32'(resp_valid), 32'd0);
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("resp_id_hold", 32'(resp_id), 32'(win));
        checkOutput("resp_data_hold", 32'(resp_data), 32'(expData));
        nxt = (left != '0) ? (1 << refWinner(left, rrPtr)) : 0;
        checkOutput("next_grant", 32'(req_ready), 32'(nxt));
    endtask

    initial begin
        int acc;
        $display("[TB] starting spi_txn_arbiter bench");
        for (int i = 0; i < NUM_REQ; i++) begin
            nArr[i]  = 8;
            txArr[i] = SPI_MAXLEN'($urandom);
        end
        #2 sresetn = 1'b0;
        tick();
        tick();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_drv_start", 32'(drv_start), 32'd0);
        checkOutput("rst_drv_n_clks", 32'(drv_n_clks), 32'd0);
        checkOutput("rst_drv_tx_data", 32'(drv_tx_data), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_id", 32'(resp_id), 32'd0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rst_resp_data", 32'(resp_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        sresetn = 1'b1;
        tick();

        // Fairness: everyone asks continuously, grants must rotate 0,1,2,3,...
        drvRxMode = 1'b0;
        drvLat    = 2;
        for (int k = 0; k < 8; k++) begin
            doTxn(4'hF, 0, 1'b0, 1'b0);
            checkOutput("fair_order", 32'(resp_id), 32'(k % NUM_REQ));
        end

        // Single loopback request, with a requester that appears and withdraws mid-flight.
        nArr[2]  = 8;
        txArr[2] = 16'h00A5;
        doTxn(4'b0100, 0, 1'b0, 1'b1);
        checkOutput("single_data", 32'(resp_data), 32'h00A5);

        nArr[0] = 0;
        doTxn(4'b0001, 0, 1'b0, 1'b0);
        nArr[1] = 17;
        doTxn(4'b0010, 0, 1'b0, 1'b0);

        drvRxMode  = 1'b1;
        drvRxConst = 16'hFFFF;
        nArr[3]    = 16;
        doTxn(4'b1000, 0, 1'b0, 1'b0);
        checkOutput("full_len_data", 32'(resp_data), 32'hFFFF);
        nArr[0] = 4;
        doTxn(4'b0001, 0, 1'b0, 1'b0);
        checkOutput("mask_data", 32'(resp_data), 32'h000F);

        drvRxMode = 1'b0;
        nArr[1]   = 12;
        doTxn(4'b0010, 3, 1'b0, 1'b0);

        nArr[2] = 9;
        doTxn(4'b0100, 0, 1'b1, 1'b0);
        nArr[3] = 10;
        doTxn(4'b1000, 0, 1'b0, 1'b0);
        checkOutput("after_timeout_err", 32'(resp_err), 32'd0);

        for (int r = 0; r < 40; r++) begin
            int sel;
            for (int i = 0; i < NUM_REQ; i++) begin
                sel = $urandom_range(0, 9);
                if (sel == 0)      nArr[i] = 0;
                else if (sel == 1) nArr[i] = $urandom_range(17, 31);
                else if (sel == 2) nArr[i] = 16;
                else               nArr[i] = $urandom_range(1, 16);
                txArr[i] = SPI_MAXLEN'($urandom);
            end
            drvLat     = $urandom_range(0, 6);
            drvRxMode  = 1'($urandom_range(0, 1));
            drvRxConst = SPI_MAXLEN'($urandom);
            doTxn(NUM_REQ'($urandom_range(1, 15)), $urandom_range(0, 3),
                  1'($urandom_range(0, 7) == 0), 1'b0);
        end

        // Reset in the middle of WAIT_DONE: no response, pointer back to 0.
        drvRxMode = 1'b0;
        drvLat    = 20;
        nArr[2]   = 8;
        txArr[2]  = 16'h1234;
        applyStimulus(4'b0100);
        tick();
        acc = cyc;
        req_valid = '0;
        repeat (4) tick();
        checkOutput("mid_busy", 32'(busy), 32'd1);
        checkOutput("mid_cycles", 32'(cyc - acc), 32'd4);
        sresetn = 1'b0;
        #1;
        checkOutput("arst_drv_start", 32'(drv_start), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_drv_n_clks", 32'(drv_n_clks), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("arst_no_resp", 32'(resp_valid), 32'd0);
        end
        sresetn = 1'b1;
        rrPtr   = 0;
        drvLat  = 2;
        tick();
        nArr[1] = 8;
        nArr[3] = 8;
        doTxn(4'b1010, 0, 1'b0, 1'b0);
        checkOutput("post_reset_first", 32'(resp_id), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
